// File: rtl/rv32_lsu_pkg.sv
// rtl/rv32_lsu_pkg.sv - shared types and byte-lane helpers for the RV32 load/store unit
package rv32_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_type_e;

    typedef struct packed {
        logic       we;
        logic [1:0] typ;
        logic       sext;
        logic [1:0] off;
        logic       split;
        logic       is_hi;
    } trk_entry_t;

    // Lanes [3:0] belong to the low word, lanes [7:4] spill into the next word.
    function automatic logic [7:0] be_span(input logic [1:0] typ, input logic [1:0] off);
        logic [7:0] base;
        case (typ)
            LSU_B:   base = 8'b0000_0001;
            LSU_H:   base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] off);
        return ((typ == LSU_H) && (off == 2'd3)) ||
               ((typ != LSU_B) && (typ != LSU_H) && (off != 2'd0));
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] off);
        return 32'({w, w} >> (6'd32 - {1'b0, off, 3'b000}));
    endfunction

    function automatic logic [31:0] funnel(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off);
        return 32'({hi, lo} >> {off, 3'b000});
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] typ,
                                                input logic sext);
        case (typ)
            LSU_B:   return {{24{sext & d[7]}}, d[7:0]};
            LSU_H:   return {{16{sext & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/rv32_lsu_trk_fifo.sv
// rtl/rv32_lsu_trk_fifo.sv - in-order tracker FIFO of outstanding bus transactions
module rv32_lsu_trk_fifo
    import rv32_lsu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  trk_entry_t    push_data,
    input  logic          pop,
    output trk_entry_t    head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free
);
    localparam int PW = $clog2(DEPTH);

    trk_entry_t    slots [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop)  rptr <= inc(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wptr] <= push_data;
    end

    assign head = slots[rptr];
    assign free = CW'(DEPTH) - count;

endmodule

// File: rtl/rv32_lsu_obi.sv
// rtl/rv32_lsu_obi.sv - RV32I LSU front-end to OBI data bus; LSU_MISALIGN_EN enables split misaligned access
module rv32_lsu_obi
    import rv32_lsu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI} state_e;

    state_e        state, state_nxt;
    logic [1:0]    off;
    logic          misal, split_in, reject, accept, push, rsp;
    logic          we_q, sext_q, split_q;
    logic [1:0]    typ_q, off_q;
    logic [29:0]   addr_q;
    logic [7:0]    be_q;
    logic [31:0]   wdata_q, stage_q;
    trk_entry_t    head;
    logic [CW-1:0] count, free;

    assign off   = lsu_addr_i[1:0];
    assign misal = is_misaligned(lsu_type_i, off);

`ifdef LSU_MISALIGN_EN
    assign split_in = misal;
    assign reject   = 1'b0;
`else
    assign split_in = 1'b0;
    assign reject   = misal;
`endif

    // A rejected op completes immediately, so it must wait until nothing is in flight to keep order.
    assign lsu_ready_o = rst_n && (state == IDLE) && (free >= CW'(2)) && !(reject && (count != '0));
    assign accept      = lsu_valid_i && lsu_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            split_q <= 1'b0;
            typ_q   <= 2'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= lsu_we_i;
                sext_q  <= lsu_sext_i;
                split_q <= split_in;
                typ_q   <= lsu_type_i;
                off_q   <= off;
                addr_q  <= lsu_addr_i[31:2];
                be_q    <= be_span(lsu_type_i, off);
                wdata_q <= rotl_bytes(lsu_wdata_i, off);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !reject) state_nxt = REQ_LO;
            REQ_LO:  if (data_gnt_i) state_nxt = split_q ? REQ_HI : IDLE;
            REQ_HI:  if (data_gnt_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign data_req_o   = (state != IDLE);
    assign data_addr_o  = {addr_q + 30'(state == REQ_HI), 2'b00};
    assign data_be_o    = (state == REQ_HI) ? be_q[7:4] : be_q[3:0];
    assign data_we_o    = we_q;
    assign data_wdata_o = wdata_q;

    assign push = data_req_o && data_gnt_i;
    assign rsp  = data_rvalid_i && (count != '0);

    rv32_lsu_trk_fifo #(.DEPTH(MAX_OUTSTANDING)) u_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{we: we_q, typ: typ_q, sext: sext_q, off: off_q,
                      split: split_q, is_hi: (state == REQ_HI)}),
        .pop       (data_rvalid_i),
        .head      (head),
        .count     (count),
        .free      (free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q        <= '0;
            lsu_rvalid_o   <= 1'b0;
            lsu_rdata_o    <= '0;
            lsu_misalign_o <= 1'b0;
        end else begin
            lsu_rvalid_o   <= 1'b0;
            lsu_misalign_o <= 1'b0;
            if (accept && reject) begin
                lsu_rvalid_o   <= 1'b1;
                lsu_rdata_o    <= '0;
                lsu_misalign_o <= 1'b1;
            end else if (rsp) begin
                if (head.split && !head.is_hi) begin
                    stage_q <= data_rdata_i;
                end else begin
                    lsu_rvalid_o <= 1'b1;
                    lsu_rdata_o  <= head.we ? 32'h0 :
                        load_extend(head.split ? funnel(data_rdata_i, stage_q, head.off)
                                               : funnel(32'h0, data_rdata_i, head.off),
                                    head.typ, head.sext);
                end
            end
        end
    end

endmodule

// File: doc/rv32_lsu_obi.md
# rv32_lsu_obi

Load/store unit front-end for the RV32I core. It accepts one load or store per handshake from the execute stage and drives the OBI-style data interface of the data-memory BFM. It generates byte enables and rotates write data, and tracks outstanding transactions in order. Returned words are aligned and sign- or zero-extended before being handed back to writeback.

## Interface
Parameters:
- MAX_OUTSTANDING, 2 — tracker depth in bus transactions; must be ≥ 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- lsu_valid_i  in  1  execute-stage operation valid.
- lsu_ready_o  out  1  operation accepted when valid & ready.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_type_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- lsu_sext_i  in  1  sign-extend load result.
- lsu_addr_i  in  32  effective byte address.
- lsu_wdata_i  in  32  store data, LSB-justified.
- lsu_rvalid_o  out  1  one-cycle completion pulse per accepted operation.
- lsu_rdata_o  out  32  load result; 0 for stores.
- lsu_misalign_o  out  1  one-cycle pulse: misaligned operation rejected (see Configuration).
- data_req_o  out  1  bus request.
- data_addr_o  out  32  word-aligned bus address.
- data_we_o  out  1  bus write.
- data_be_o  out  4  bus byte enables.
- data_wdata_o  out  32  rotated write data.
- data_gnt_i  in  1  bus grant; may be combinational on data_req_o.
- data_rvalid_i  in  1  bus response valid; responses return in order.
- data_rdata_i  in  32  bus response data.

## Operation
- FSM states:
  - IDLE: ready when tracker free slots ≥ 2. On accept, latch the request fields and go to REQ_LO.
  - REQ_LO: data_req_o=1. On data_gnt_i, go to REQ_HI if the operation is split, otherwise to IDLE.
  - REQ_HI: data_req_o=1, address = lo address + 4. On data_gnt_i, go to IDLE.
- Byte offset off = lsu_addr_i[1:0].
- Byte enables:
  - byte: 0001<<off.
  - half: 0011<<off.
  - word: 1111<<off for the low transaction; the high transaction uses 1111>>(4-off).
  - Bits shifted beyond bit 3 go to the high transaction.
- Write data is rotated left by 8·off. The same rotated word is driven on both halves of a split.
- Misaligned: half with off=3; word with off≠0.
- Each grant pushes a tracker entry {we, type, sext, off, split, is_hi}. Each data_rvalid_i pops the head entry.
- Load result, non-split: data_rdata_i >> 8·off, then truncated to the type width and extended per sext.
- Load result, split: the low word is held in a staging register. The result is ({hi_word, lo_word} >> 8·off)[31:0], then extended.
- lsu_rvalid_o is asserted once per operation, on the response to the final transaction.
- A data_rvalid_i arriving with an empty tracker is ignored and does not pop.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and the tracker to empty.
- Accept in cycle T → data_req_o high from T+1 (registered).
- Bus-side stability: address, we, be and wdata are held stable while data_req_o=1 and not granted. data_req_o is never withdrawn before grant.
- Sustained throughput: one non-split operation per 2 cycles with a zero-wait grant.
- lsu_rvalid_o and lsu_rdata_o are registered: they appear in the cycle after the final data_rvalid_i.
- Grant and rvalid in the same cycle: tracker count is unchanged; both push and pop happen.
- Tracker pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation flushes the FSM, tracker and staging register. No completion pulse is issued for abandoned operations.

## Configuration
- LSU_MISALIGN_EN defined:
  - Misaligned operations are split into two word transactions, low then high.
  - lsu_misalign_o stays 0.
- LSU_MISALIGN_EN undefined:
  - Misaligned operations are accepted but generate no bus transaction.
  - lsu_misalign_o pulses in the cycle after accept; lsu_rvalid_o pulses in the same cycle with lsu_rdata_o=0.
  - The FSM stays in IDLE, and no store side effect occurs.

## Structure
- Package rv32_lsu_pkg holds:
  - lsu_type_e (LSU_B, LSU_H, LSU_W).
  - The tracker-entry struct.
  - Byte-enable and extension helper functions.
- Sub-module rv32_lsu_trk_fifo: synchronous FIFO, MAX_OUTSTANDING deep, with push, pop, count and free outputs, asynchronous active-low reset.

## Test plan
- Aligned word store of 0xDEADBEEF to 0x2010, then a load from 0x2010 → lsu_rdata_o=0xDEADBEEF; data_be_o=1111 on both transactions.
- Byte store of 0xAB to 0x2013, then a signed byte load → data_be_o=1000, data_wdata_o=0xAB000000; load result 0xFFFFFFAB, or 0x000000AB with sext=0.
- Half load from 0x2002, memory word 0x80017FFF, sext=1 → lsu_rdata_o=0xFFFF8001.
- With LSU_MISALIGN_EN, word load from 0x2011, words 0x44332211 at 0x2010 and 0x88776655 at 0x2014:
  - Two transactions, with be 1110 then 0001.
  - lsu_rdata_o=0x55443322; exactly one lsu_rvalid_o pulse.
- Without LSU_MISALIGN_EN, the same access → no data_req_o, lsu_misalign_o=1 for one cycle, lsu_rdata_o=0.
- Back-to-back loads under random grant delays of 1–8 cycles and response delays of 1–12 cycles:
  - Results come back in issue order.
  - lsu_ready_o stays low when free slots < 2.
  - Asserting rst_n=0 mid-flight clears data_req_o and lsu_rvalid_o on the next edge.
